// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with a 2-entry output FIFO.
// Each accepted immediate is extended combinationally according to in_mode
// and stored together with its tag and an illegal-mode flag. The FIFO decouples
// the producer from the consumer. in_ready is derived from occupancy only, so
// there is no combinational path from out_ready to in_ready.
// OUT_W must be at least IN_W+2.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [7:0]       err_count
);

    // Entry layout: {result, tag, err}
    localparam int EW = OUT_W + TAG_W + 1;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_res;
    logic             ext_err;
    logic [EW-1:0]    mem [2];
    logic [EW-1:0]    head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             push;
    logic             pop;

    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    // Extension of the incoming immediate; modes 4-7 yield zero with the error flag.
    always_comb begin
        ext_res = '0;
        ext_err = 1'b0;
        case (in_mode)
            3'd0:    ext_res = sext;
            3'd1:    ext_res = {{(OUT_W-IN_W){1'b0}}, in_imm};
            3'd2:    ext_res = {in_imm, {(OUT_W-IN_W){1'b0}}};
            3'd3:    ext_res = sext << 2;
            default: ext_err = 1'b1;
        endcase
    end

    assign in_ready  = (occ < 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Outputs are forced to zero whenever the FIFO is empty, which also makes
    // reset take effect on them immediately without clearing the storage.
    assign head    = mem[rd_ptr];
    assign out_imm = out_valid ? head[EW-1 -: OUT_W] : '0;
    assign out_tag = out_valid ? head[TAG_W:1] : '0;
    assign out_err = out_valid && head[0];

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ext_res, in_tag, ext_err};
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    // Saturating count of accepted illegal-mode entries; untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (push && ext_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against a queue-based model.
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [2:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [7:0]       err_count;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     tag;
        bit     err;
    } entry_t;

    entry_t q[$];
    int     ref_ecnt = 0;
    int     errors = 0;
    int     checks = 0;

    localparam longint OMASK = (longint'(1) << OUT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic entry_t ref_ext(input longint imm, input int mode, input int tag);
        entry_t e;
        longint s;
        s = (imm >= (longint'(1) << (IN_W-1))) ? imm - (longint'(1) << IN_W) : imm;
        e.tag = tag;
        e.err = 1'b0;
        case (mode)
            0: e.val = s & OMASK;
            1: e.val = imm;
            2: e.val = (imm * (longint'(1) << (OUT_W-IN_W))) & OMASK;
            3: e.val = (s * 4) & OMASK;
            default: begin e.val = 0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check_model();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("err_count", err_count, ref_ecnt);
        if (q.size() > 0) begin
            chk("out_imm", out_imm, q[0].val);
            chk("out_tag", out_tag, q[0].tag);
            chk("out_err", out_err, q[0].err);
        end else begin
            chk("idle_imm", out_imm, 0);
            chk("idle_tag", out_tag, 0);
            chk("idle_err", out_err, 0);
        end
    endtask

    // Drive one cycle: inputs set now, model checked and advanced mid-cycle,
    // returns shortly after the next rising edge.
    task automatic step(input bit v, input int imm, input int mode, input int tag,
                        input bit ordy, input bit fl);
        bit acc, deq;
        entry_t e;
        in_valid  = v;
        in_imm    = IN_W'(imm);
        in_mode   = 3'(mode);
        in_tag    = TAG_W'(tag);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_model();
        acc = v && (q.size() < 2) && !fl;
        deq = (q.size() > 0) && ordy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) begin
                e = ref_ext(longint'(imm) & ((longint'(1) << IN_W) - 1), mode, tag);
                q.push_back(e);
                if (e.err && ref_ecnt < 255) ref_ecnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ecnt", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic extension modes, first accept right after reset
        step(1, 'h8004, 0, 3, 1, 0);
        chk("m0_valid", out_valid, 1);
        chk("m0_imm", out_imm, 32'hFFFF8004);
        chk("m0_tag", out_tag, 3);
        chk("m0_err", out_err, 0);
        step(1, 'h8004, 1, 4, 1, 0);
        chk("m1_imm", out_imm, 32'h00008004);
        step(1, 'h8004, 2, 5, 1, 0);
        chk("m2_imm", out_imm, 32'h80040000);
        step(1, 'h8004, 3, 6, 1, 0);
        chk("m3_imm", out_imm, 32'hFFFE0010);
        step(0, 0, 0, 0, 1, 0);

        // backpressure: third push refused
        step(1, 'h0011, 1, 1, 0, 0);
        step(1, 'h0022, 1, 2, 0, 0);
        chk("full_ready", in_ready, 0);
        step(1, 'h0033, 1, 7, 0, 0);
        chk("stall_imm", out_imm, 32'h11);
        step(0, 0, 0, 0, 1, 0);
        chk("drain1_imm", out_imm, 32'h22);
        chk("drain1_tag", out_tag, 2);
        step(0, 0, 0, 0, 1, 0);
        chk("drain_empty", out_valid, 0);

        // simultaneous push and pop at occupancy 1
        step(1, 'h0100, 1, 8, 0, 0);
        step(1, 'h0200, 1, 9, 1, 0);
        chk("pp_valid", out_valid, 1);
        chk("pp_imm", out_imm, 32'h200);
        chk("pp_ready", in_ready, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("pp_empty", out_valid, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 70, int'($urandom_range(16'hFFFF)),
                 int'($urandom_range(7)), int'($urandom_range(31)),
                 $urandom_range(99) < 60, $urandom_range(29) == 0);
        end

        // flush with one entry buffered and an illegal input arriving
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        begin
            int e0;
            e0 = ref_ecnt;
            step(1, 'h1234, 0, 1, 0, 0);
            step(1, 'h5555, 5, 2, 0, 1);
            chk("flush1_valid", out_valid, 0);
            chk("flush1_ecnt", err_count, e0);
            step(1, 'h1, 0, 1, 0, 0);
            step(1, 'h2, 0, 2, 0, 0);
            step(1, 'h3, 6, 3, 0, 1);
            chk("flush2_valid", out_valid, 0);
            chk("flush2_ecnt", err_count, e0);
        end

        // illegal mode saturation
        for (int i = 0; i < 300; i++) begin
            step(1, int'($urandom_range(16'hFFFF)), 5, i % 32, 1, 0);
        end
        chk("sat_ecnt", err_count, 255);
        chk("sat_imm", out_imm, 0);
        chk("sat_err", out_err, 1);
        step(0, 0, 0, 0, 1, 0);

        // asynchronous reset with two entries buffered
        step(1, 'hAAAA, 0, 1, 0, 0);
        step(1, 'hBBBB, 3, 2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_imm", out_imm, 0);
        chk("arst_tag", out_tag, 0);
        chk("arst_err", out_err, 0);
        chk("arst_ecnt", err_count, 0);
        chk("arst_ready", in_ready, 1);
        q.delete();
        ref_ecnt = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1, 'h7FFF, 0, 9, 1, 0);
        chk("post_rst_imm", out_imm, 32'h00007FFF);
        step(0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
